// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues req/gnt/rvalid fetches to instruction memory
// and buffers returned words in a small FIFO presented to decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] INST_NOP   = 32'h0000_0013
) (
    input  logic        sys_clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_en_i,
    input  logic        PCSrc_i,
    input  logic [31:0] branch_target_i,
    output logic        instruction_valid_o,
    output logic [31:0] instruction_addr_o,
    output logic [31:0] instruction_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t          DEPTH_CNT  = cnt_t'(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_WIDE = (CW + 1)'(FIFO_DEPTH);

    logic [31:0] pc_q, pc_d;
    cnt_t        inflight_q, inflight_d;
    cnt_t        discard_q, discard_d;

    logic [31:0] aq_addr_q [FIFO_DEPTH];
    logic [31:0] aq_addr_d [FIFO_DEPTH];
    ptr_t        aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;

    logic [31:0] df_addr_q [FIFO_DEPTH];
    logic [31:0] df_addr_d [FIFO_DEPTH];
    logic [31:0] df_inst_q [FIFO_DEPTH];
    logic [31:0] df_inst_d [FIFO_DEPTH];
    ptr_t        df_wr_q, df_wr_d, df_rd_q, df_rd_d;
    cnt_t        df_cnt_q, df_cnt_d;

    logic        valid, pop, req, grant, rsp_ok, drop, push;
    logic [CW:0] used;
    logic        unused_target_lsbs;

    assign unused_target_lsbs = ^branch_target_i[1:0];

    assign valid = (df_cnt_q != '0);
    assign pop   = valid && !stall_en_i && !PCSrc_i;

    // Credit = in-flight + buffered, counting this cycle's pop as already freed.
    assign used  = {1'b0, inflight_q} + {1'b0, df_cnt_q} - (CW + 1)'(pop);
    assign req   = !rst_i && !PCSrc_i && (used < DEPTH_WIDE);
    assign grant = req && imem_gnt_i;

    // Responses with nothing outstanding are a protocol error and are ignored.
    assign rsp_ok = imem_rvalid_i && (inflight_q != '0);
    assign drop   = rsp_ok && ((discard_q != '0) || PCSrc_i);
    assign push   = rsp_ok && !drop && (df_cnt_q != DEPTH_CNT);

    assign imem_req_o          = req;
    assign imem_addr_o         = pc_q;
    assign instruction_valid_o = valid;
    assign instruction_addr_o  = df_addr_q[df_rd_q];
    assign instruction_o       = valid ? df_inst_q[df_rd_q] : INST_NOP;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        aq_addr_d  = aq_addr_q;
        aq_wr_d    = aq_wr_q;
        aq_rd_d    = aq_rd_q;
        df_addr_d  = df_addr_q;
        df_inst_d  = df_inst_q;
        df_wr_d    = df_wr_q;
        df_rd_d    = df_rd_q;
        df_cnt_d   = df_cnt_q;

        if (PCSrc_i) begin
            pc_d = {branch_target_i[31:2], 2'b00};
        end else if (grant) begin
            pc_d = pc_q + 32'd4;
        end

        if (grant) begin
            aq_addr_d[aq_wr_q] = pc_q;
            aq_wr_d            = aq_wr_q + ptr_t'(1);
        end
        if (rsp_ok) begin
            aq_rd_d = aq_rd_q + ptr_t'(1);
        end

        inflight_d = inflight_q + cnt_t'(grant) - cnt_t'(rsp_ok);

        // Every response still outstanding after a redirect belongs to the old path.
        if (PCSrc_i) begin
            discard_d = inflight_q - cnt_t'(rsp_ok);
        end else if (drop && (discard_q != '0)) begin
            discard_d = discard_q - cnt_t'(1);
        end

        if (PCSrc_i) begin
            df_cnt_d = '0;
            df_rd_d  = df_wr_q;
        end else begin
            if (push) begin
                df_addr_d[df_wr_q] = aq_addr_q[aq_rd_q];
                df_inst_d[df_wr_q] = imem_rdata_i;
                df_wr_d            = df_wr_q + ptr_t'(1);
            end
            if (pop) begin
                df_rd_d = df_rd_q + ptr_t'(1);
            end
            df_cnt_d = df_cnt_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            pc_q       <= {RESET_PC[31:2], 2'b00};
            inflight_q <= '0;
            discard_q  <= '0;
            aq_wr_q    <= '0;
            aq_rd_q    <= '0;
            df_wr_q    <= '0;
            df_rd_q    <= '0;
            df_cnt_q   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                aq_addr_q[i] <= '0;
                df_addr_q[i] <= '0;
                df_inst_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            aq_wr_q    <= aq_wr_d;
            aq_rd_q    <= aq_rd_d;
            df_wr_q    <= df_wr_d;
            df_rd_q    <= df_rd_d;
            df_cnt_q   <= df_cnt_d;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                aq_addr_q[i] <= aq_addr_d[i];
                df_addr_q[i] <= df_addr_d[i];
                df_inst_q[i] <= df_inst_d[i];
            end
        end
    end

endmodule
